aes_top: RTL and testbench

Iterative AES-128 encryption core (FIPS-197, encrypt only): captures a 128-bit plaintext block and a 128-bit key and produces the ciphertext after ten rounds, one round per clock. It is the top of the AES datapath and is driven directly by the system bus/test harness. Round keys are expanded on the fly, alongside the data rounds.

---
 rtl/aes_top.sv | 176 +++++++++++++++++
 tb/tb_aes_top.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_top.sv
// -----------------------------------------------------------------------------
// aes_top
// Iterative AES-128 encryption core (encrypt only). One round per clock; round
// keys are expanded on the fly alongside the data rounds.
//
// Ports
//   AES_clk             system clock, rising-edge active
//   AES_rst_n           asynchronous active-low reset
//   AES_en              start request, sampled while idle
//   AES_data_in  [127:0] plaintext  ([127:120] = byte 0, [7:0] = byte 15)
//   AES_key_in   [127:0] cipher key (same byte ordering)
//   AES_data_out [127:0] ciphertext register, holds until next completion
//   AES_data_out_valid  one-cycle pulse marking a new AES_data_out
//
// Handshake: AES_en is a level request, no ready. It is accepted on any rising
// edge at which the core is IDLE; the 128-bit inputs are sampled on that edge
// only. AES_data_out_valid is a single-cycle strobe with no back-pressure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} fsm_t;

    // Forward S-box; element 255 is the entry for input 0x00, so look up with ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t         fsm;
    logic [3:0]   round;
    logic [127:0] st;
    logic [127:0] rk;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte index = 4*column + row; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next round key from the current one (round counter selects Rcon).
    logic [31:0]  w0, w1, w2, w3, temp, n0, n1, n2, n3;
    logic [127:0] next_rk;
    assign w0      = rk[127:96];
    assign w1      = rk[95:64];
    assign w2      = rk[63:32];
    assign w3      = rk[31:0];
    assign temp    = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                   ^ {rcon(round), 24'h000000};
    assign n0      = w0 ^ temp;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    // SubBytes and ShiftRows commute; the final round skips MixColumns.
    logic [127:0] sb_sr;
    logic [127:0] mixed;
    assign sb_sr = shift_rows(sub_bytes(st));
    assign mixed = mix_columns(sb_sr);

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm                <= IDLE;
            round              <= 4'd0;
            st                 <= '0;
            rk                 <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    AES_data_out_valid <= 1'b0;
                    if (AES_en) begin
                        rk    <= AES_key_in;
                        st    <= AES_data_in ^ AES_key_in;
                        round <= 4'd1;
                        fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    rk <= next_rk;
                    if (round == 4'd10) begin
                        AES_data_out       <= sb_sr ^ next_rk;
                        AES_data_out_valid <= 1'b1;
                        round              <= 4'd0;
                        fsm                <= IDLE;
                    end else begin
                        st    <= mixed ^ next_rk;
                        round <= round + 4'd1;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    round <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_top.sv
// -----------------------------------------------------------------------------
// tb_aes_top
// Self-checking bench for aes_top. Expected ciphertexts come from FIPS-197
// vectors or from a behavioural AES model whose S-box is derived from GF(2^8)
// inversion plus the affine transform. The driver pushes the expected value
// and the expected valid cycle; the monitor checks AES_data_out_valid on every
// cycle and compares AES_data_out when a pulse is due.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_top;

    logic         AES_clk;
    logic         AES_rst_n;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    aes_top dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid)
    );

    // ---------------- clock / reset ----------------
    initial AES_clk = 1'b0;
    always #5 AES_clk = ~AES_clk;

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q[$];
    int           cyc_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [7:0]   tb_sbox[256];

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] key,
                                               input logic [127:0] pt);
        logic [31:0]  w[44];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [7:0]   s[16];
        logic [7:0]   u[16];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]], tb_sbox[t[31:24]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) u[4*c+r] = s[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gf_mul(u[4*c],8'h02)^gf_mul(u[4*c+1],8'h03)^u[4*c+2]^u[4*c+3];
                    s[4*c+1] = u[4*c]^gf_mul(u[4*c+1],8'h02)^gf_mul(u[4*c+2],8'h03)^u[4*c+3];
                    s[4*c+2] = u[4*c]^u[4*c+1]^gf_mul(u[4*c+2],8'h02)^gf_mul(u[4*c+3],8'h03);
                    s[4*c+3] = gf_mul(u[4*c],8'h03)^u[4*c+1]^u[4*c+2]^gf_mul(u[4*c+3],8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = u[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic exp_valid;
        forever begin
            @(posedge AES_clk);
            cyc++;
            #1;
            exp_valid = (cyc_q.size() > 0) && (cyc_q[0] == cyc);
            check("valid", {127'd0, AES_data_out_valid}, {127'd0, exp_valid});
            if (exp_valid) begin
                check("data", AES_data_out, exp_q[0]);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge AES_clk);
            n++;
        end
        check("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic run_one(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] expected);
        @(negedge AES_clk);
        AES_key_in  = key;
        AES_data_in = pt;
        AES_en      = 1'b1;
        exp_q.push_back(expected);
        cyc_q.push_back(cyc + 1 + 10);
        @(negedge AES_clk);
        AES_en = 1'b0;
        wait_idle();
        repeat (2) @(negedge AES_clk);
        check("hold_after_done", AES_data_out, expected);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] k, p, e;
        logic [127:0] busy_vals[3];
        int cap;

        build_sbox();
        AES_rst_n   = 1'b0;
        AES_en      = 1'b1;
        AES_data_in = rand128();
        AES_key_in  = rand128();

        // Reset held with random inputs and a start request.
        for (int i = 0; i < 5; i++) begin
            @(negedge AES_clk);
            AES_data_in = rand128();
            AES_key_in  = rand128();
            check("reset_out", AES_data_out, 128'd0);
        end
        @(negedge AES_clk);
        AES_en    = 1'b0;
        AES_rst_n = 1'b1;

        // Reset in the middle of an encryption: no pulse, output stays 0.
        @(negedge AES_clk);
        AES_key_in  = rand128();
        AES_data_in = rand128();
        AES_en      = 1'b1;
        @(negedge AES_clk);
        AES_en = 1'b0;
        repeat (4) @(negedge AES_clk);
        AES_rst_n = 1'b0;
        #1;
        check("abort_out", AES_data_out, 128'd0);
        repeat (2) @(negedge AES_clk);
        AES_rst_n = 1'b1;
        repeat (20) @(negedge AES_clk);
        check("abort_hold", AES_data_out, 128'd0);

        // Known-answer vectors.
        run_one(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_one(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32);
        run_one(128'd0, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // Random vectors against the model.
        for (int i = 0; i < 4; i++) begin
            k = rand128();
            p = rand128();
            run_one(k, p, aes_model(k, p));
        end

        // AES_en held high for 51 cycles: captures every 11 cycles.
        k = rand128();
        p = rand128();
        e = aes_model(k, p);
        @(negedge AES_clk);
        AES_key_in  = k;
        AES_data_in = p;
        AES_en      = 1'b1;
        cap = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(e);
            cyc_q.push_back(cap + 11*i + 10);
        end
        repeat (51) @(negedge AES_clk);
        AES_en = 1'b0;
        wait_idle();
        repeat (15) @(negedge AES_clk);
        check("b2b_hold", AES_data_out, e);

        // Inputs churn while busy; only the T0 values count.
        busy_vals[0] = 128'ha6f2daeb0123456789abcdef01234567;
        busy_vals[1] = 128'hd7b262480f1e2d3c4b5a69788796a5b4;
        busy_vals[2] = 128'hf301a68a13579bdf02468ace13579bdf;
        k = rand128();
        p = rand128();
        e = aes_model(k, p);
        @(negedge AES_clk);
        AES_key_in  = k;
        AES_data_in = p;
        AES_en      = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1 + 10);
        for (int i = 1; i <= 10; i++) begin
            @(negedge AES_clk);
            AES_data_in = (i <= 3) ? busy_vals[i-1] : rand128();
            AES_key_in  = rand128();
            AES_en      = 1'($urandom_range(0, 1));
        end
        @(negedge AES_clk);
        AES_en = 1'b0;
        wait_idle();
        repeat (15) @(negedge AES_clk);
        check("churn_hold", AES_data_out, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
